// File: rtl/regwr_arb_if.sv
// Register-file write-port arbiter bus.
// Carries the writeback and mult/div request signals into the arbiter, and
// carries the register-file write port, hazard mask, stall request and FIFO
// occupancy back out.
//   slave  : arbiter side (requests in, write port and status out)
//   master : environment side (requests out, write port and status in)
interface regwr_arb_if #(
    parameter int DEPTH = 4
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             wb_we;
    logic [4:0]       wb_reg;
    logic [31:0]      wb_data;
    logic             mu_valid;
    logic             mu_ready;
    logic [4:0]       mu_reg;
    logic [31:0]      mu_data;
    logic             regwrite;
    logic [4:0]       wrreg;
    logic [31:0]      wrdata;
    logic [31:0]      pend_mask;
    logic             stall_req;
    logic [CNT_W-1:0] fifo_cnt;

    modport slave (
        input  wb_we, wb_reg, wb_data, mu_valid, mu_reg, mu_data,
        output mu_ready, regwrite, wrreg, wrdata, pend_mask, stall_req, fifo_cnt
    );

    modport master (
        output wb_we, wb_reg, wb_data, mu_valid, mu_reg, mu_data,
        input  mu_ready, regwrite, wrreg, wrdata, pend_mask, stall_req, fifo_cnt
    );
endinterface

// File: rtl/regwr_arb.sv
// Write-port arbiter for the 32x32 register file.
// Shares the single write port between the writeback stage (always wins,
// cannot be stalled) and the mult/div unit (valid/ready). Mult/div results
// wait in a DEPTH-entry FIFO; an empty FIFO lets a result bypass straight to
// the port. A head that waits STARVE_MAX cycles, or a full FIFO, raises
// stall_req so the pipeline inserts a writeback bubble.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : regwr_arb_if.slave (wb_*, mu_* requests in; regwrite/wrreg/
//              wrdata, pend_mask, stall_req, mu_ready, fifo_cnt out)
module regwr_arb #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    regwr_arb_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_MAX);

    logic [4:0]       mem_reg_r  [DEPTH];
    logic [31:0]      mem_data_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [AGE_W-1:0] age_r;
    logic             regwrite_r;
    logic [4:0]       wrreg_r;
    logic [31:0]      wrdata_r;
    logic [31:0]      pend_mask_r;
    logic             stall_req_r;
    logic             mu_ready_r;

    logic             wb_req_s, mu_live_s, empty_s;
    logic             pop_s, push_s, bypass_s;
    logic             grant_s;
    logic [4:0]       gnt_reg_s;
    logic [31:0]      gnt_data_s;
    logic [PTR_W-1:0] rd_ptr_n_s, wr_ptr_n_s, off_s;
    logic [CNT_W-1:0] cnt_n_s;
    logic [AGE_W-1:0] age_n_s;
    logic [31:0]      mask_n_s;
    logic [4:0]       slot_reg_s;

    // Arbitration, FIFO pointer/count update, head age and next pend_mask.
    always_comb begin
        // mu_reg==0 transfers complete the handshake but are dropped.
        wb_req_s  = bus.wb_we && (bus.wb_reg != 5'd0);
        mu_live_s = bus.mu_valid && mu_ready_r && (bus.mu_reg != 5'd0);
        empty_s   = (cnt_r == {CNT_W{1'b0}});
        pop_s     = !wb_req_s && !empty_s;
        bypass_s  = !wb_req_s && empty_s && mu_live_s;
        push_s    = mu_live_s && !bypass_s;

        grant_s    = 1'b0;
        gnt_reg_s  = wrreg_r;
        gnt_data_s = wrdata_r;
        if (wb_req_s) begin
            grant_s    = 1'b1;
            gnt_reg_s  = bus.wb_reg;
            gnt_data_s = bus.wb_data;
        end else if (pop_s) begin
            grant_s    = 1'b1;
            gnt_reg_s  = mem_reg_r[rd_ptr_r];
            gnt_data_s = mem_data_r[rd_ptr_r];
        end else if (bypass_s) begin
            grant_s    = 1'b1;
            gnt_reg_s  = bus.mu_reg;
            gnt_data_s = bus.mu_data;
        end else begin
            grant_s    = 1'b0;
        end

        case ({push_s, pop_s})
            2'b10:   cnt_n_s = cnt_r + CNT_W'(1);
            2'b01:   cnt_n_s = cnt_r - CNT_W'(1);
            default: cnt_n_s = cnt_r;
        endcase

        // Pointer arithmetic wraps naturally because DEPTH is a power of two.
        if (pop_s) begin
            rd_ptr_n_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_n_s = rd_ptr_r;
        end
        if (push_s) begin
            wr_ptr_n_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_n_s = wr_ptr_r;
        end

        if (empty_s || pop_s) begin
            age_n_s = {AGE_W{1'b0}};
        end else if (age_r != AGE_MAX) begin
            age_n_s = age_r + AGE_W'(1);
        end else begin
            age_n_s = age_r;
        end

        // A slot is live when its distance from the next read pointer is
        // below the next count; the slot being pushed shows its new register.
        mask_n_s   = 32'd0;
        slot_reg_s = 5'd0;
        off_s      = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (push_s && (wr_ptr_r == PTR_W'(i))) begin
                slot_reg_s = bus.mu_reg;
            end else begin
                slot_reg_s = mem_reg_r[i];
            end
            off_s = PTR_W'(i) - rd_ptr_n_s;
            if ({1'b0, off_s} < cnt_n_s) begin
                mask_n_s = mask_n_s | (32'd1 << slot_reg_s);
            end else begin
                mask_n_s = mask_n_s;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg_r[i]  <= 5'd0;
                mem_data_r[i] <= 32'd0;
            end
            rd_ptr_r    <= {PTR_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            age_r       <= {AGE_W{1'b0}};
            regwrite_r  <= 1'b0;
            wrreg_r     <= 5'd0;
            wrdata_r    <= 32'd0;
            pend_mask_r <= 32'd0;
            stall_req_r <= 1'b0;
            mu_ready_r  <= 1'b1;
        end else begin
            if (push_s) begin
                mem_reg_r[wr_ptr_r]  <= bus.mu_reg;
                mem_data_r[wr_ptr_r] <= bus.mu_data;
            end
            rd_ptr_r    <= rd_ptr_n_s;
            wr_ptr_r    <= wr_ptr_n_s;
            cnt_r       <= cnt_n_s;
            age_r       <= age_n_s;
            regwrite_r  <= grant_s;
            wrreg_r     <= gnt_reg_s;
            wrdata_r    <= gnt_data_s;
            pend_mask_r <= mask_n_s;
            stall_req_r <= (age_n_s == AGE_MAX) || (cnt_n_s == FULL_CNT);
            mu_ready_r  <= (cnt_n_s != FULL_CNT);
        end
    end

    assign bus.regwrite  = regwrite_r;
    assign bus.wrreg     = wrreg_r;
    assign bus.wrdata    = wrdata_r;
    assign bus.pend_mask = pend_mask_r;
    assign bus.stall_req = stall_req_r;
    assign bus.mu_ready  = mu_ready_r;
    assign bus.fifo_cnt  = cnt_r;
endmodule

// File: tb/tb_regwr_arb.sv
// Self-checking bench for regwr_arb: a directed vector table walking through
// the main arbitration, starvation, full-FIFO and reset cases, followed by
// randomized traffic checked against a queue-based reference model.
module tb_regwr_arb;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regwr_arb_if #(.DEPTH(DEPTH)) bus ();

    regwr_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: buffered mu writes as a queue.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;
    ent_t        q[$];
    int          m_age;
    logic        m_rw;
    logic [4:0]  m_wrreg;
    logic [31:0] m_wrdata;

    typedef struct {
        logic        rst;
        logic        wb_we;
        logic [4:0]  wb_reg;
        logic [31:0] wb_data;
        logic        mu_valid;
        logic [4:0]  mu_reg;
        logic [31:0] mu_data;
        logic        e_rw;
        logic [4:0]  e_wrreg;
        int          e_cnt;
        logic [31:0] e_mask;
        logic        e_stall;
        logic        e_ready;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        ent_t e;
        bit   was_empty, popped, live;
        if (rst) begin
            q.delete();
            m_age    = 0;
            m_rw     = 1'b0;
            m_wrreg  = 5'd0;
            m_wrdata = 32'd0;
        end else begin
            was_empty = (q.size() == 0);
            popped    = 1'b0;
            live      = bus.mu_valid && (q.size() != DEPTH) && (bus.mu_reg != 5'd0);
            m_rw      = 1'b0;
            if (bus.wb_we && bus.wb_reg != 5'd0) begin
                m_rw = 1'b1; m_wrreg = bus.wb_reg; m_wrdata = bus.wb_data;
            end else if (!was_empty) begin
                e = q.pop_front();
                popped = 1'b1;
                m_rw = 1'b1; m_wrreg = e.r; m_wrdata = e.d;
            end else if (live) begin
                m_rw = 1'b1; m_wrreg = bus.mu_reg; m_wrdata = bus.mu_data;
                live = 1'b0;
            end
            if (live) begin
                e.r = bus.mu_reg;
                e.d = bus.mu_data;
                q.push_back(e);
            end
            if (was_empty || popped) m_age = 0;
            else if (m_age < STARVE_MAX) m_age = m_age + 1;
        end
    endtask

    // Clock once and compare every output against the model.
    task automatic cycle_and_check(input string tag);
        logic [31:0] mask;
        model_step();
        @(posedge clk);
        #1;
        mask = 32'd0;
        foreach (q[i]) mask = mask | (32'd1 << q[i].r);
        chk({tag, ".regwrite"},  32'(bus.regwrite),  32'(m_rw));
        chk({tag, ".wrreg"},     32'(bus.wrreg),     32'(m_wrreg));
        chk({tag, ".wrdata"},    bus.wrdata,         m_wrdata);
        chk({tag, ".fifo_cnt"},  32'(bus.fifo_cnt),  32'(q.size()));
        chk({tag, ".pend_mask"}, bus.pend_mask,      mask);
        chk({tag, ".stall_req"}, 32'(bus.stall_req),
            32'((m_age == STARVE_MAX) || (q.size() == DEPTH)));
        chk({tag, ".mu_ready"},  32'(bus.mu_ready),  32'(q.size() != DEPTH));
    endtask

    function automatic vec_t mk(input logic r, input logic we, input logic [4:0] wr,
                                input logic [31:0] wd, input logic mv, input logic [4:0] mr,
                                input logic [31:0] md, input logic erw, input logic [4:0] ewr,
                                input int ecnt, input logic [31:0] emask,
                                input logic est, input logic erdy);
        vec_t v;
        v.rst = r; v.wb_we = we; v.wb_reg = wr; v.wb_data = wd;
        v.mu_valid = mv; v.mu_reg = mr; v.mu_data = md;
        v.e_rw = erw; v.e_wrreg = ewr; v.e_cnt = ecnt; v.e_mask = emask;
        v.e_stall = est; v.e_ready = erdy;
        return v;
    endfunction

    initial begin
        int wb_pct;
        bus.wb_we = 1'b0; bus.wb_reg = 5'd0; bus.wb_data = 32'd0;
        bus.mu_valid = 1'b0; bus.mu_reg = 5'd0; bus.mu_data = 32'd0;

        //            rst  we   wreg   wdata          mv   mreg   mdata       rw   wrreg  cnt mask           st   rdy
        vt.push_back(mk(1'b1,1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,      1'b0,5'd0, 0,32'h00000000,1'b0,1'b1));
        vt.push_back(mk(1'b0,1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,      1'b0,5'd0, 0,32'h00000000,1'b0,1'b1));
        vt.push_back(mk(1'b0,1'b1,5'd5, 32'hDEADBEEF, 1'b0,5'd0, 32'd0,      1'b1,5'd5, 0,32'h00000000,1'b0,1'b1));
        vt.push_back(mk(1'b0,1'b1,5'd0, 32'h55,       1'b0,5'd0, 32'd0,      1'b0,5'd5, 0,32'h00000000,1'b0,1'b1));
        vt.push_back(mk(1'b0,1'b0,5'd0, 32'd0,        1'b1,5'd9, 32'h1234,   1'b1,5'd9, 0,32'h00000000,1'b0,1'b1));
        vt.push_back(mk(1'b0,1'b1,5'd3, 32'h33,       1'b1,5'd8, 32'h8888,   1'b1,5'd3, 1,32'h00000100,1'b0,1'b1));
        vt.push_back(mk(1'b0,1'b1,5'd3, 32'h33,       1'b1,5'd10,32'hAAAA,   1'b1,5'd3, 2,32'h00000500,1'b0,1'b1));
        vt.push_back(mk(1'b0,1'b1,5'd3, 32'h33,       1'b0,5'd0, 32'd0,      1'b1,5'd3, 2,32'h00000500,1'b0,1'b1));
        vt.push_back(mk(1'b0,1'b1,5'd3, 32'h33,       1'b0,5'd0, 32'd0,      1'b1,5'd3, 2,32'h00000500,1'b1,1'b1));
        vt.push_back(mk(1'b0,1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,      1'b1,5'd8, 1,32'h00000400,1'b0,1'b1));
        vt.push_back(mk(1'b0,1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,      1'b1,5'd10,0,32'h00000000,1'b0,1'b1));
        vt.push_back(mk(1'b0,1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,      1'b0,5'd10,0,32'h00000000,1'b0,1'b1));
        vt.push_back(mk(1'b0,1'b1,5'd3, 32'h33,       1'b1,5'd20,32'h20,     1'b1,5'd3, 1,32'h00100000,1'b0,1'b1));
        vt.push_back(mk(1'b0,1'b1,5'd3, 32'h33,       1'b1,5'd21,32'h21,     1'b1,5'd3, 2,32'h00300000,1'b0,1'b1));
        vt.push_back(mk(1'b0,1'b1,5'd3, 32'h33,       1'b1,5'd22,32'h22,     1'b1,5'd3, 3,32'h00700000,1'b0,1'b1));
        vt.push_back(mk(1'b0,1'b1,5'd3, 32'h33,       1'b1,5'd23,32'h23,     1'b1,5'd3, 4,32'h00F00000,1'b1,1'b0));
        vt.push_back(mk(1'b0,1'b1,5'd3, 32'h33,       1'b1,5'd24,32'h24,     1'b1,5'd3, 4,32'h00F00000,1'b1,1'b0));
        vt.push_back(mk(1'b0,1'b0,5'd0, 32'd0,        1'b1,5'd24,32'h24,     1'b1,5'd20,3,32'h00E00000,1'b0,1'b1));
        vt.push_back(mk(1'b0,1'b0,5'd0, 32'd0,        1'b1,5'd24,32'h24,     1'b1,5'd21,3,32'h01C00000,1'b0,1'b1));
        vt.push_back(mk(1'b1,1'b1,5'd3, 32'h33,       1'b1,5'd25,32'h25,     1'b0,5'd0, 0,32'h00000000,1'b0,1'b1));
        vt.push_back(mk(1'b0,1'b0,5'd0, 32'd0,        1'b0,5'd0, 32'd0,      1'b0,5'd0, 0,32'h00000000,1'b0,1'b1));
        vt.push_back(mk(1'b0,1'b0,5'd0, 32'd0,        1'b1,5'd0, 32'h77,     1'b0,5'd0, 0,32'h00000000,1'b0,1'b1));

        foreach (vt[i]) begin
            rst = vt[i].rst;
            bus.wb_we = vt[i].wb_we; bus.wb_reg = vt[i].wb_reg; bus.wb_data = vt[i].wb_data;
            bus.mu_valid = vt[i].mu_valid; bus.mu_reg = vt[i].mu_reg; bus.mu_data = vt[i].mu_data;
            cycle_and_check($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.t_regwrite", i), 32'(bus.regwrite), 32'(vt[i].e_rw));
            chk($sformatf("vec%0d.t_wrreg", i),    32'(bus.wrreg),    32'(vt[i].e_wrreg));
            chk($sformatf("vec%0d.t_cnt", i),      32'(bus.fifo_cnt), 32'(vt[i].e_cnt));
            chk($sformatf("vec%0d.t_mask", i),     bus.pend_mask,     vt[i].e_mask);
            chk($sformatf("vec%0d.t_stall", i),    32'(bus.stall_req), 32'(vt[i].e_stall));
            chk($sformatf("vec%0d.t_ready", i),    32'(bus.mu_ready), 32'(vt[i].e_ready));
        end
        // The wb write in the table must also carry its data.
        rst = 1'b0;
        bus.wb_we = 1'b1; bus.wb_reg = 5'd5; bus.wb_data = 32'hDEADBEEF;
        bus.mu_valid = 1'b0;
        cycle_and_check("wbdata");
        chk("wbdata.t_wrdata", bus.wrdata, 32'hDEADBEEF);

        // Randomized traffic with varying writeback load.
        wb_pct = 50;
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) wb_pct = $urandom_range(10, 95);
            rst          = ($urandom_range(0, 199) == 0);
            bus.wb_we    = ($urandom_range(0, 99) < wb_pct);
            bus.wb_reg   = 5'($urandom_range(0, 31));
            bus.wb_data  = $urandom;
            bus.mu_valid = ($urandom_range(0, 99) < 60);
            bus.mu_reg   = 5'($urandom_range(0, 31));
            bus.mu_data  = $urandom;
            cycle_and_check("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
